seq_mul_div: RTL

Parametrised iterative multiply/divide unit. It is the successor to the single-operation shift-add multiplier.
- Adds signed mode, restoring division, a busy flag and divide-by-zero reporting.
- Latency is fixed and data-independent.
- Sits beside the datapath as a multi-cycle arithmetic co-unit with a set/ready handshake.

---
 rtl/seq_mul_div_pkg.sv | 22 ++
 rtl/seq_mul_div_step.sv | 35 +++
 rtl/seq_mul_div.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seq_mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// FSM state encoding, operation encoding and a counter-width helper.
package seq_mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Bits needed to hold values 0..n-1 (call with N+1 to count 0..N).
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_mul_div_step.sv
// One combinational iteration of the engine: shift-add multiply step or
// restoring-division step on a 2N+1 bit accumulator {partial(N+1), shift(N)}.
module mul_div_step
  import seq_mul_div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           op,
  input  logic [2*N:0]   acc,
  input  logic [N-1:0]   md,
  output logic [2*N:0]   acc_next
);

  logic [N:0]   mul_sum;
  logic [2*N:0] mul_next;
  logic [2*N:0] shifted;
  logic [N+1:0] diff;
  logic [2*N:0] div_next;

  always_comb begin
    mul_sum  = acc[2*N:N] + (acc[0] ? {1'b0, md} : {(N+1){1'b0}});
    mul_next = {1'b0, mul_sum, acc[N-1:1]};

    // Remainder sits in the upper N+1 bits, dividend/quotient shifts in the low N.
    shifted  = {acc[2*N-1:0], 1'b0};
    diff     = {1'b0, shifted[2*N:N]} - {2'b00, md};
    if (!diff[N+1])
      div_next = {diff[N:0], shifted[N-1:1], 1'b1};
    else
      div_next = shifted;

    acc_next = (op == OP_DIV) ? div_next : mul_next;
  end

endmodule

// File: rtl/seq_mul_div.sv
// Iterative N-bit multiply/divide co-unit with fixed N+2 cycle latency,
// signed/unsigned modes and divide-by-zero reporting.
module seq_mul_div
  import seq_mul_div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           set,
  input  logic           op,
  input  logic           sign,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           ready,
  output logic [2*N-1:0] r,
  output logic           div_by_zero
);

  localparam int CW = clog2(N + 1);

  state_t          state, state_next;
  logic            load, step_en, fix_en;
  logic [CW-1:0]   cnt;
  logic [2*N:0]    acc, acc_next;
  logic [N-1:0]    md;
  logic [N-1:0]    a_raw;
  logic            op_r, res_neg, dvd_neg, b_zero;
  logic [N-1:0]    a_mag, b_mag;
  logic [N-1:0]    quot, rem;
  logic [2*N-1:0]  result;

  assign a_mag = (sign && a[N-1]) ? -a : a;
  assign b_mag = (sign && b[N-1]) ? -b : b;

  mul_div_step #(.N(N)) u_step (
    .op       (op_r),
    .acc      (acc),
    .md       (md),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step_en    = 1'b0;
    fix_en     = 1'b0;
    case (state)
      IDLE: if (set) begin
        load       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        step_en = 1'b1;
        if (cnt == CW'(N - 1)) state_next = FIX;
      end
      FIX: begin
        fix_en     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign correction applied in FIX; divide-by-zero returns {a, all-ones} verbatim.
  always_comb begin
    quot   = acc[N-1:0];
    rem    = acc[2*N-1:N];
    result = acc[2*N-1:0];
    if (op_r == OP_MUL) begin
      if (res_neg) result = -acc[2*N-1:0];
    end else if (b_zero) begin
      result = {a_raw, {N{1'b1}}};
    end else begin
      if (res_neg) quot = -acc[N-1:0];
      if (dvd_neg) rem  = -acc[2*N-1:N];
      result = {rem, quot};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      md          <= '0;
      a_raw       <= '0;
      op_r        <= OP_MUL;
      res_neg     <= 1'b0;
      dvd_neg     <= 1'b0;
      b_zero      <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (load) begin
        op_r        <= op;
        a_raw       <= a;
        md          <= b_mag;
        acc         <= {{(N+1){1'b0}}, a_mag};
        res_neg     <= sign & (a[N-1] ^ b[N-1]);
        dvd_neg     <= sign & a[N-1];
        b_zero      <= (b == '0);
        cnt         <= '0;
        busy        <= 1'b1;
        div_by_zero <= 1'b0;
      end
      if (step_en) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      if (fix_en) begin
        r           <= result;
        div_by_zero <= (op_r == OP_DIV) && b_zero;
        ready       <= 1'b1;
        busy        <= 1'b0;
      end
    end
  end

endmodule
